key_schedule_seq: RTL and testbench



---
 rtl/key_schedule_seq_if.sv | 30 +++
 rtl/key_schedule_seq.sv | 176 +++++++++++++++++
 tb/tb_key_schedule_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_seq_if.sv
// ---------------------------------------------------------------------------
// key_schedule_seq_if
// Bus between a requester and the AES-128 key-expansion engine.
//   start    : request expansion of key (requester -> engine)
//   key      : 128-bit cipher key, w0 in [127:96] (requester -> engine)
//   busy     : expansion in progress (engine -> requester)
//   done     : a complete schedule is held (engine -> requester)
//   schedule : all 11 round keys, round r at [1407-128r -: 128]
//   rk_sel   : round-key select, 0..10 (requester -> engine)
//   rk_out   : round key rk_sel, zero when rk_sel > 10 (engine -> requester)
// ---------------------------------------------------------------------------
interface key_schedule_seq_if;
  logic            start;
  logic [127:0]    key;
  logic            busy;
  logic            done;
  logic [1407:0]   schedule;
  logic [3:0]      rk_sel;
  logic [127:0]    rk_out;

  modport master (
    output start, key, rk_sel,
    input  busy, done, schedule, rk_out
  );

  modport slave (
    input  start, key, rk_sel,
    output busy, done, schedule, rk_out
  );
endinterface

// File: rtl/key_schedule_seq.sv
// ---------------------------------------------------------------------------
// key_schedule_seq
// Sequential AES-128 key expansion. Four S-box lookups, registered on the
// falling clock edge, are shared across rounds: each round takes one SUB
// cycle (S-box settles on RotWord of the last word) and one UPD cycle (new
// round key is written). The full 11-key schedule is held until the next
// accepted start.
//   CLK   : clock, posedge domain; the S-box registers use the negedge
//   RESET : synchronous active-high reset
//   bus   : key_schedule_seq_if.slave (start/key/busy/done/schedule/rk_*)
// ---------------------------------------------------------------------------

// One SubBytes byte lookup, captured on the falling edge so the result is
// stable for the second half of the SUB cycle and all of the UPD cycle.
module key_schedule_sbox (
  input  logic       CLK,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (254 = sum of 2^1..2^7), then the
  // FIPS-197 affine map. x = 0 naturally yields 0 before the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Pure pipeline register: its content is only consumed after a SUB cycle
  // has refreshed it, so it needs no reset.
  always_ff @(negedge CLK) begin
    dout <= sbox(din);
  end
endmodule

module key_schedule_seq #(
  parameter int NR = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  key_schedule_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SUB, UPD, DONE} state_t;

  state_t       state, state_nx;
  logic [3:0]   rnd;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] rk [0:NR];
  logic         load_key, upd;
  logic [31:0]  rot, s, t, n0, n1, n2, n3;
  logic [7:0]   rcon;

  // S-box input comes only from the registered working word w3.
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    key_schedule_sbox u_sbox (
      .CLK  (CLK),
      .din  (rot[8*b +: 8]),
      .dout (s[8*b +: 8])
    );
  end

  always_comb begin
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = s ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // NOTE: every output of this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    load_key = 1'b0;
    upd      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load_key = 1'b1;
          state_nx = SUB;
        end
      end
      SUB: state_nx = UPD;
      UPD: begin
        upd      = 1'b1;
        state_nx = (rnd == 4'(NR)) ? DONE : SUB;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      rnd   <= 4'd1;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      // NOTE: the round-key store is a visible output and a half-built
      // schedule must not survive reset, so unlike a plain RAM it is cleared.
      for (int r = 0; r <= NR; r++) rk[r] <= '0;
    end else begin
      state <= state_nx;
      if (load_key) begin
        rnd   <= 4'd1;
        w0    <= bus.key[127:96];
        w1    <= bus.key[95:64];
        w2    <= bus.key[63:32];
        w3    <= bus.key[31:0];
        rk[0] <= bus.key;
        for (int r = 1; r <= NR; r++) rk[r] <= '0;
      end
      if (upd) begin
        rk[rnd] <= {n0, n1, n2, n3};
        w0      <= n0;
        w1      <= n1;
        w2      <= n2;
        w3      <= n3;
        if (rnd != 4'(NR)) rnd <= rnd + 4'd1;
      end
    end
  end

  assign bus.busy = (state == SUB) || (state == UPD);
  assign bus.done = (state == DONE);

  for (genvar r = 0; r <= NR; r++) begin : g_sched
    assign bus.schedule[1407 - 128*r -: 128] = rk[r];
  end

  always_comb begin
    bus.rk_out = '0;
    if (bus.rk_sel <= 4'(NR)) bus.rk_out = rk[bus.rk_sel];
  end
endmodule

// File: tb/tb_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// tb_key_schedule_seq
// Scoreboard bench for key_schedule_seq. Accepted starts push the expected
// schedule and completion cycle; a negedge monitor pops on each rising done.
// The reference model is the textbook word-recurrence key expansion with an
// S-box table built from the generator-3 walk of GF(2^8).
// ---------------------------------------------------------------------------
module tb_key_schedule_seq;
  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  typedef struct {
    logic [1407:0] sched;
    int            cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] sbox_tab [256];

  key_schedule_seq_if bus ();

  key_schedule_seq #(.NR(10)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1407:0] act, input logic [1407:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1407:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
               sbox_tab[tmp[15:8]],  sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) out[1407 - 32*i -: 32] = w[i];
    return out;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; push an expectation if the engine should accept.
  task automatic start_exp(input logic [127:0] k, input bit accept);
    exp_t e;
    bus.key   = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (accept) begin
      e.sched = expand(k);
      e.cyc   = cyc + 20;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", bus.done, 1);
    tick();
  endtask

  // Monitor: compares on each rising done.
  int busy_cnt;
  bit prev_done;
  initial begin
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("schedule", bus.schedule, e.sched);
          check("done_latency", cyc, e.cyc);
          check("busy_cycles", busy_cnt, 20);
        end
      end
      busy_cnt  = (bus.busy === 1'b1) ? busy_cnt + 1 : 0;
      prev_done = (bus.done === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  initial begin
    logic [1407:0] fips_exp;
    logic [127:0]  slice;
    cyc       = 0;
    n_checks  = 0;
    n_errors  = 0;
    build_sbox();
    fips_exp   = expand(FIPS_KEY);
    bus.start  = 1'b0;
    bus.key    = '0;
    bus.rk_sel = '0;
    reset      = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_schedule", bus.schedule, 0);

    // FIPS-197 vector
    start_exp(FIPS_KEY, 1);
    check("busy_after_accept", bus.busy, 1);
    wait_done();
    bus.rk_sel = 4'd1;
    #1 check("fips_round1", bus.rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    bus.rk_sel = 4'd10;
    #1 check("fips_round10", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // rk_sel sweep
    for (int r = 0; r < 16; r++) begin
      bus.rk_sel = 4'(r);
      slice = (r <= 10) ? fips_exp[1407 - 128*r -: 128] : 128'h0;
      #1 check($sformatf("rk_out_sel%0d", r), bus.rk_out, slice);
    end

    // All-zero key, started from DONE
    start_exp(ZERO_KEY, 1);
    wait_done();
    bus.rk_sel = 4'd1;
    #1 check("zero_round1", bus.rk_out, 128'h62636363626363636263636362636363);
    bus.rk_sel = 4'd10;
    #1 check("zero_round10", bus.rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Start pulse mid-expansion with another key is ignored
    start_exp(FIPS_KEY, 1);
    repeat (6) tick();
    start_exp({$urandom, $urandom, $urandom, $urandom}, 0);
    wait_done();

    // Reset mid-expansion discards everything
    start_exp(ZERO_KEY, 1);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check("midreset_busy", bus.busy, 0);
    check("midreset_done", bus.done, 0);
    check("midreset_schedule", bus.schedule, 0);
    start_exp(FIPS_KEY, 1);
    wait_done();

    // start held high in DONE restarts at once; old rounds are cleared
    bus.rk_sel = 4'd1;
    bus.key    = ZERO_KEY;
    bus.start  = 1'b1;
    tick();
    begin
      exp_t e;
      e.sched = expand(ZERO_KEY);
      e.cyc   = cyc + 20;
      sb_q.push_back(e);
    end
    check("restart_done_low", bus.done, 0);
    check("restart_round1_cleared", bus.rk_out, 0);
    check("restart_round0", bus.schedule[1407:1280], ZERO_KEY);
    repeat (2) tick();
    bus.start = 1'b0;
    wait_done();

    // Random keys
    for (int i = 0; i < 4; i++) begin
      start_exp({$urandom, $urandom, $urandom, $urandom}, 1);
      wait_done();
    end

    repeat (2) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
